// File: rtl/fir_pkg.sv
// Shared definitions for the FIR back-end: default widths, the Q2.8 sample type
// and the round-and-saturate helper used wherever a wide FIR result returns to Q2.8.
package fir_pkg;

    localparam int INBIT_DEF  = 23;
    localparam int OUTBIT_DEF = 11;
    localparam int SHIFT_DEF  = 8;

    // Q2.8: 1 sign, 2 integer, 8 fraction bits
    typedef logic signed [OUTBIT_DEF-1:0] q28_t;

    localparam int SAT_MAX = (1 << (OUTBIT_DEF - 1)) - 1;
    localparam int SAT_MIN = -(1 << (OUTBIT_DEF - 1));

    typedef struct packed {
        logic sat;
        q28_t val;
    } rq_res_t;

    // Round half toward +inf, arithmetic shift, then clip to the Q2.8 range.
    // Evaluated in 64 bits so the rounding add can never wrap for any sane input width.
    function automatic rq_res_t round_sat(input logic signed [63:0] x,
                                          input int unsigned       shift);
        logic signed [63:0] t;
        rq_res_t            r;
        t = (x + (64'sd1 <<< (shift - 32'd1))) >>> shift;
        r.sat = 1'b0;
        r.val = t[OUTBIT_DEF-1:0];
        if (t > 64'(SAT_MAX)) begin
            r.sat = 1'b1;
            r.val = q28_t'(SAT_MAX);
        end else if (t < 64'(SAT_MIN)) begin
            r.sat = 1'b1;
            r.val = q28_t'(SAT_MIN);
        end
        return r;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO with a registered head word. The head register is loaded
// from next-state storage so a push into an empty FIFO is visible right after that edge.
module sample_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic             head_valid_o,
    output logic             full_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             empty, full, pop_ok, push_ok;

    // Next-state for pointers, occupancy, storage and the registered head
    always_comb begin
        empty   = (cnt_q == '0);
        full    = (cnt_q == CW'(DEPTH));
        pop_ok  = pop_i && !empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts
        push_ok = push_i && (!full || pop_ok);

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_q] = push_data_i;
        end
        wr_d  = push_ok ? wr_q + AW'(1) : wr_q;
        rd_d  = pop_ok ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q;
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push_ok && pop_ok) begin
            cnt_d = cnt_q - CW'(1);
        end
        valid_d = (cnt_d != '0);
        head_d  = valid_d ? mem_d[rd_d] : '0;
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            valid_q <= valid_d;
        end
    end

    assign head_data_o  = head_q;
    assign head_valid_o = valid_q;
    assign full_o       = full;

endmodule

// File: rtl/fir_decim_requant.sv
// FIR back-end: drops the pipeline warm-up, decimates by M, requantises to Q2.8
// and hands samples to the consumer through a small valid/ready FIFO.
module fir_decim_requant
    import fir_pkg::*;
#(
    parameter int INBIT  = INBIT_DEF,
    parameter int OUTBIT = OUTBIT_DEF,
    parameter int SHIFT  = SHIFT_DEF,
    parameter int M      = 2,
    parameter int SKIP   = 33,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INBIT-1:0]  in_data,
    input  logic              clr,
    output logic [OUTBIT-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sat_flag,
    output logic              ovf_flag
);

    localparam int WW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
    localparam int PW = (M > 1) ? $clog2(M) : 1;

    logic [WW-1:0]     warm_q, warm_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic [INBIT-1:0]  in_q, in_d;
    logic              keep_q, keep_d;
    logic [OUTBIT-1:0] rq_q, rq_d;
    logic              rq_vld_q, rq_vld_d;
    logic              sat_q, sat_d;
    logic              ovf_q, ovf_d;
    logic              warm_done;
    logic              sat_evt, ovf_evt;
    logic              fifo_full;
    rq_res_t           res;

    // Warm-up/phase counters, input capture, requant stage and sticky flags
    always_comb begin
        warm_done = (warm_q == WW'(SKIP));
        warm_d    = warm_done ? warm_q : warm_q + WW'(1);

        phase_d = phase_q;
        if (warm_done) begin
            phase_d = (phase_q == PW'(M - 1)) ? '0 : phase_q + PW'(1);
        end

        in_d   = in_data;
        keep_d = warm_done && (phase_q == '0);

        res      = round_sat(64'($signed(in_q)), SHIFT);
        rq_d     = OUTBIT'(res.val);
        rq_vld_d = keep_q;
        sat_evt  = keep_q && res.sat;

        // Dropped only when full and no pop frees a slot this cycle
        ovf_evt = rq_vld_q && fifo_full && !(out_ready && out_valid);

        // New events win over a simultaneous clear
        sat_d = (sat_q && !clr) || sat_evt;
        ovf_d = (ovf_q && !clr) || ovf_evt;
    end

    // Pipeline and control registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            warm_q   <= '0;
            phase_q  <= '0;
            in_q     <= '0;
            keep_q   <= 1'b0;
            rq_q     <= '0;
            rq_vld_q <= 1'b0;
            sat_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            warm_q   <= warm_d;
            phase_q  <= phase_d;
            in_q     <= in_d;
            keep_q   <= keep_d;
            rq_q     <= rq_d;
            rq_vld_q <= rq_vld_d;
            sat_q    <= sat_d;
            ovf_q    <= ovf_d;
        end
    end

    sample_fifo #(
        .WIDTH (OUTBIT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk),
        .rst_ni       (rst),
        .push_i       (rq_vld_q),
        .push_data_i  (rq_q),
        .pop_i        (out_ready),
        .head_data_o  (out_data),
        .head_valid_o (out_valid),
        .full_o       (fifo_full)
    );

    assign sat_flag = sat_q;
    assign ovf_flag = ovf_q;

endmodule

// File: doc/fir_decim_requant.md
# fir_decim_requant

Downstream stage of the 32-tap symmetric FIR. It takes the FIR's free-running 23-bit output, discards the pipeline warm-up transient after reset, and decimates by M. It then rounds and saturates each kept sample back to the 11-bit Q2.8 sample format and delivers it through a small FIFO with a valid/ready handshake. The consumer is the next DSP or output stage.

## Interface
Parameters:
- INBIT, 23, width of FIR output sample (signed).
- OUTBIT, 11, width of requantised sample (signed Q2.8: 1 sign, 2 integer, 8 fraction).
- SHIFT, 8, arithmetic right shift removing the tap scaling (taps sum ≈ 256).
- M, 2, decimation factor, ≥1 (M=1 means pass-through rate).
- SKIP, 33, FIR outputs discarded after reset (FIR pipeline fill).
- DEPTH, 4, output FIFO entries (power of two, ≥2).

Ports:
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- in_data, in, INBIT, FIR output; one new sample every clk, no valid.
- clr, in, 1, synchronous clear of sticky flags (sat_flag, ovf_flag) only.
- out_data, out, OUTBIT, FIFO head sample.
- out_valid, out, 1, out_data holds a valid sample.
- out_ready, in, 1, consumer accepts; a transfer occurs on out_valid && out_ready at a clk edge.
- sat_flag, out, 1, sticky: at least one kept sample saturated.
- ovf_flag, out, 1, sticky: at least one kept sample dropped because the FIFO was full.

## Operation
- Reset (rst=0, async) sets:
  - out_valid=0, out_data=0, sat_flag=0, ovf_flag=0.
  - Warm-up counter=0, phase counter=0, FIFO empty.
- Warm-up: the first SKIP in_data samples after reset deassertion are ignored. Sample index SKIP is the first one eligible.
- Decimation: after warm-up, the phase counter cycles 0..M-1, one step per clk. A sample is kept when phase==0, so the first eligible sample is kept, then every M-th.
- Requantise each kept sample:
  - Compute t = (in_data + 2^(SHIFT-1)) >>> SHIFT, in INBIT+1 bits (round half toward +inf).
  - Saturate t to [-2^(OUTBIT-1), 2^(OUTBIT-1)-1], i.e. [-1024, 1023].
  - Set sat_flag if t was clipped.
- FIFO write: a kept, requantised sample is written unless the FIFO is full. If it is full, the sample is dropped and ovf_flag is set.
- Simultaneous pop and push when full: the pop frees the slot and the push is accepted; occupancy is unchanged and no overflow occurs.
- Simultaneous push and pop when empty is impossible, because out_valid=0 when empty.
- clr=1 clears both sticky flags. If a new saturation or overflow event occurs in the same cycle, the flag stays set (set wins).
- Counters saturate/hold once warm-up is done. The phase counter wraps M-1→0.

## Timing
- Stage 1: in_data is sampled at edge t. Round/saturate is registered at edge t+1.
- Stage 2: the FIFO write occurs at edge t+2.
- Latency: out_valid rises after edge t+2 if the FIFO was empty, so there are 2 clk of latency from a kept sample to out_valid.
- out_data is the registered FIFO head and is stable while out_valid && !out_ready.
- Throughput: at most one kept sample every M cycles. Sustained out_ready=1 therefore never overflows.
- sat_flag is set at edge t+1; ovf_flag is set at edge t+2.
- Reset mid-operation immediately empties the FIFO and restarts warm-up; in-flight samples are lost.

## Structure
- Shared package `fir_pkg`:
  - INBIT/OUTBIT/SHIFT default constants.
  - Q2.8 sample typedef.
  - Saturation limit constants.
  - Round-and-saturate function, reused by later stages.
- One sub-module: `sample_fifo`.
  - Parameterised width/depth synchronous FIFO.
  - Async active-low reset.
  - Push/pop, full/empty, registered head output.
- Top level holds the warm-up counter, phase counter, requant register and flag logic.

## Test plan
- Warm-up/decimation (M=2): drive in_data = 256·n on cycle n after reset with out_ready=1. The first output is 33, then 35, 37, …; each appears 2 cycles after its input cycle; no flags set.
- Rounding:
  - in_data = 25727 → out_data 100.
  - 25728 → 101.
  - -25728 → -100.
  - -25729 → -101.
  - sat_flag stays 0.
- Saturation:
  - in_data = 4194303 → 1023.
  - -4194304 → -1024.
  - sat_flag=1 until a clr pulse, after which it reads 0.
- Backpressure: with out_ready=0 after warm-up, 4 kept samples fill the FIFO and the 5th is dropped with ovf_flag=1. Then set out_ready=1: the 4 stored samples drain in order, one per clk.
- Full pop+push: with the FIFO full, assert out_ready=1 exactly on the cycle a kept sample is pushed. The sample is accepted, occupancy stays 4, and ovf_flag stays 0.
- Reset mid-stream: assert rst=0 asynchronously with the FIFO half full. out_valid, out_data and the flags go to 0 at once. After release, no output appears before 33 + 2 cycles.
